// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL lock sequencer: state encoding and output widths.
package pll_seq_pkg;

    localparam int STATE_W  = 3;
    localparam int RELOCK_W = 8;

    typedef enum logic [STATE_W-1:0] {
        RESET_HOLD = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABILIZE  = 3'd2,
        RUN        = 3'd3,
        FAULT      = 3'd4
    } state_t;

    // Saturating increment so a flapping PLL cannot wrap the loss count back to zero.
    function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
        return (v == '1) ? v : v + RELOCK_W'(1);
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous status inputs.
module sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on the reference clock: hold, wait for lock with retries, stabilize, run.
// Optional restart input enabled by defining PLL_SEQ_RESTART_EN.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOSS_FILTER   = 4,
    parameter int MAX_RETRIES   = 7,
    parameter int CNT_W         = 20
) (
    input  logic                refclk,
    input  logic                rst_n,
`ifdef PLL_SEQ_RESTART_EN
    input  logic                restart,
`endif
    input  logic                pll_locked,
    output logic                pll_rst,
    output logic                ready,
    output logic                fault,
    output logic [RELOCK_W-1:0] relock_count,
    output logic [STATE_W-1:0]  state
);

    localparam int RETRY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOSS_LAST   = CNT_W'(LOSS_FILTER - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRIES - 1);
    localparam longint             CNT_SPAN    = longint'(1) << CNT_W;

    if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 ||
        LOSS_FILTER < 1 || MAX_RETRIES < 1) begin : g_bad_min
        $error("pll_lock_sequencer: all cycle/retry parameters must be >= 1");
    end
    if (longint'(RST_CYCLES) > CNT_SPAN || longint'(LOCK_TIMEOUT) > CNT_SPAN ||
        longint'(STABLE_CYCLES) > CNT_SPAN || longint'(LOSS_FILTER) > CNT_SPAN) begin : g_bad_width
        $error("pll_lock_sequencer: CNT_W too narrow for the configured cycle counts");
    end

    state_t             cur;
    logic [CNT_W-1:0]   timer;
    logic [RETRY_W-1:0] retry;
    logic               lk;

    sync2 #(
        .WIDTH    (1),
        .RESET_VAL(1'b0)
    ) u_lock_sync (
        .clk  (refclk),
        .rst_n(rst_n),
        .d    (pll_locked),
        .q    (lk)
    );

    // The timer doubles as the consecutive-loss counter while in RUN.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cur          <= RESET_HOLD;
            timer        <= '0;
            retry        <= '0;
            pll_rst      <= 1'b1;
            ready        <= 1'b0;
            fault        <= 1'b0;
            relock_count <= '0;
        end else
`ifdef PLL_SEQ_RESTART_EN
        if (restart) begin
            cur     <= RESET_HOLD;
            timer   <= '0;
            retry   <= '0;
            pll_rst <= 1'b1;
            ready   <= 1'b0;
            fault   <= 1'b0;
        end else
`endif
        begin
            case (cur)
                RESET_HOLD: begin
                    pll_rst <= 1'b1;
                    if (timer == RST_LAST) begin
                        cur     <= WAIT_LOCK;
                        timer   <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lk) begin
                        cur   <= STABILIZE;
                        timer <= '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        timer   <= '0;
                        pll_rst <= 1'b1;
                        if (retry == RETRY_LAST) begin
                            cur   <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            cur   <= RESET_HOLD;
                            retry <= retry + RETRY_W'(1);
                        end
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                STABILIZE: begin
                    if (!lk) begin
                        cur   <= WAIT_LOCK;
                        timer <= '0;
                    end else if (timer == STABLE_LAST) begin
                        cur   <= RUN;
                        timer <= '0;
                        retry <= '0;
                        ready <= 1'b1;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (lk) begin
                        timer <= '0;
                    end else if (timer == LOSS_LAST) begin
                        cur          <= RESET_HOLD;
                        timer        <= '0;
                        ready        <= 1'b0;
                        pll_rst      <= 1'b1;
                        relock_count <= sat_inc(relock_count);
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                FAULT: begin
                    pll_rst <= 1'b1;
                    fault   <= 1'b1;
                    ready   <= 1'b0;
                end
                default: begin
                    cur     <= RESET_HOLD;
                    timer   <= '0;
                    pll_rst <= 1'b1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters; restart tests need PLL_SEQ_RESTART_EN.
module tb_pll_lock_sequencer;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       ready;
    logic       fault;
    logic [7:0] relock_count;
    logic [2:0] state;
`ifdef PLL_SEQ_RESTART_EN
    logic       restart;
`endif

    int n_compared;
    int n_mismatched;

    pll_lock_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .LOSS_FILTER  (4),
        .MAX_RETRIES  (3),
        .CNT_W        (20)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
`ifdef PLL_SEQ_RESTART_EN
        .restart     (restart),
`endif
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .ready       (ready),
        .fault       (fault),
        .relock_count(relock_count),
        .state       (state)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Inputs change and outputs are sampled on the falling edge, half a cycle from the active edge.
    task automatic tick();
        @(negedge refclk);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        tick();
        tick();
        n_compared++;
        if (pll_rst !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_pll_rst: got %0b want 1", pll_rst); end
        n_compared++;
        if (ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_ready: got %0b want 0", ready); end
        n_compared++;
        if (fault !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_fault: got %0b want 0", fault); end
        n_compared++;
        if (relock_count !== 8'd0) begin n_mismatched++; $display("[TB] FAIL reset_relock: got %0d want 0", relock_count); end
        n_compared++;
        if (state !== 3'd0) begin n_mismatched++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
        rst_n = 1'b1;
    endtask

    task automatic test_lock_sequence();
        int n;
        n = 0;
        while (n < 50) begin
            tick();
            n++;
            if (pll_rst !== 1'b1) break;
        end
        n_compared++;
        if (n !== 4) begin n_mismatched++; $display("[TB] FAIL lock_rst_width: got %0d want 4", n); end
        n_compared++;
        if (state !== 3'd1) begin n_mismatched++; $display("[TB] FAIL lock_enter_wait: got %0d want 1", state); end
        repeat (5) tick();
        n_compared++;
        if (state !== 3'd1) begin n_mismatched++; $display("[TB] FAIL lock_still_wait: got %0d want 1", state); end
        pll_locked = 1'b1;
        n = 0;
        while (n < 50) begin
            tick();
            n++;
            if (ready === 1'b1) break;
        end
        n_compared++;
        if (n !== 11) begin n_mismatched++; $display("[TB] FAIL lock_ready_latency: got %0d want 11", n); end
        n_compared++;
        if (state !== 3'd3) begin n_mismatched++; $display("[TB] FAIL lock_run_state: got %0d want 3", state); end
        n_compared++;
        if (fault !== 1'b0) begin n_mismatched++; $display("[TB] FAIL lock_fault: got %0b want 0", fault); end
        n_compared++;
        if (pll_rst !== 1'b0) begin n_mismatched++; $display("[TB] FAIL lock_pll_rst: got %0b want 0", pll_rst); end
    endtask

    task automatic test_loss_filter();
        int n;
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        repeat (6) tick();
        n_compared++;
        if (ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL glitch3_ready: got %0b want 1", ready); end
        n_compared++;
        if (relock_count !== 8'd0) begin n_mismatched++; $display("[TB] FAIL glitch3_relock: got %0d want 0", relock_count); end
        n_compared++;
        if (state !== 3'd3) begin n_mismatched++; $display("[TB] FAIL glitch3_state: got %0d want 3", state); end

        pll_locked = 1'b0;
        repeat (4) tick();
        pll_locked = 1'b1;
        tick();
        n_compared++;
        if (ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL loss4_ready_early: got %0b want 1", ready); end
        tick();
        n_compared++;
        if (ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL loss4_ready: got %0b want 0", ready); end
        n_compared++;
        if (pll_rst !== 1'b1) begin n_mismatched++; $display("[TB] FAIL loss4_pll_rst: got %0b want 1", pll_rst); end
        n_compared++;
        if (state !== 3'd0) begin n_mismatched++; $display("[TB] FAIL loss4_state: got %0d want 0", state); end
        n_compared++;
        if (relock_count !== 8'd1) begin n_mismatched++; $display("[TB] FAIL loss4_relock: got %0d want 1", relock_count); end
        n = 0;
        while (n < 100 && ready !== 1'b1) begin
            tick();
            n++;
        end
        n_compared++;
        if (ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL loss4_relocked: got %0b want 1", ready); end
    endtask

    task automatic test_stabilize_glitch();
        int n;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        tick();
        rst_n = 1'b1;
        n = 0;
        while (n < 50 && state !== 3'd1) begin
            tick();
            n++;
        end
        pll_locked = 1'b1;
        n = 0;
        while (n < 10 && state !== 3'd2) begin
            tick();
            n++;
        end
        n_compared++;
        if (state !== 3'd2) begin n_mismatched++; $display("[TB] FAIL stab_enter: got %0d want 2", state); end
        repeat (3) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        n_compared++;
        if (state !== 3'd2) begin n_mismatched++; $display("[TB] FAIL stab_before_drop: got %0d want 2", state); end
        tick();
        n_compared++;
        if (state !== 3'd1) begin n_mismatched++; $display("[TB] FAIL stab_drop_to_wait: got %0d want 1", state); end
        n_compared++;
        if (pll_rst !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stab_no_retry_rst: got %0b want 0", pll_rst); end
        tick();
        n_compared++;
        if (state !== 3'd2) begin n_mismatched++; $display("[TB] FAIL stab_reenter: got %0d want 2", state); end
        n = 0;
        while (n < 50) begin
            tick();
            n++;
            if (ready === 1'b1) break;
        end
        n_compared++;
        if (n !== 8) begin n_mismatched++; $display("[TB] FAIL stab_full_redo: got %0d want 8", n); end
    endtask

    task automatic test_timeout_fault();
        int n;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int p = 0; p < 3; p++) begin
            n = 0;
            while (n < 100) begin
                tick();
                n++;
                if (pll_rst !== 1'b1) break;
            end
            n_compared++;
            if (n !== 4) begin n_mismatched++; $display("[TB] FAIL timeout_pulse%0d_high: got %0d want 4", p, n); end
            n_compared++;
            if (fault !== 1'b0) begin n_mismatched++; $display("[TB] FAIL timeout_pulse%0d_fault: got %0b want 0", p, fault); end
            n = 0;
            while (n < 100) begin
                tick();
                n++;
                if (pll_rst !== 1'b0) break;
            end
            n_compared++;
            if (n !== 20) begin n_mismatched++; $display("[TB] FAIL timeout_pulse%0d_low: got %0d want 20", p, n); end
        end
        n_compared++;
        if (fault !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fault_flag: got %0b want 1", fault); end
        n_compared++;
        if (state !== 3'd4) begin n_mismatched++; $display("[TB] FAIL fault_state: got %0d want 4", state); end
        n_compared++;
        if (ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fault_ready: got %0b want 0", ready); end
        repeat (30) tick();
        n_compared++;
        if (fault !== 1'b1 || pll_rst !== 1'b1 || state !== 3'd4) begin
            n_mismatched++;
            $display("[TB] FAIL fault_sticky: got fault=%0b pll_rst=%0b state=%0d want 1/1/4", fault, pll_rst, state);
        end
    endtask

    task automatic test_saturation();
        int n;
        int expired;
        expired    = 0;
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            n = 0;
            while (n < 100 && ready !== 1'b1) begin
                tick();
                n++;
            end
            if (ready !== 1'b1) expired++;
            pll_locked = 1'b0;
            n = 0;
            while (n < 20 && ready !== 1'b0) begin
                tick();
                n++;
            end
            if (ready !== 1'b0) expired++;
            pll_locked = 1'b1;
            if (i == 1) begin
                n_compared++;
                if (relock_count !== 8'd1) begin n_mismatched++; $display("[TB] FAIL sat_first: got %0d want 1", relock_count); end
            end
            if (i == 255) begin
                n_compared++;
                if (relock_count !== 8'd255) begin n_mismatched++; $display("[TB] FAIL sat_255: got %0d want 255", relock_count); end
            end
        end
        n_compared++;
        if (expired !== 0) begin n_mismatched++; $display("[TB] FAIL sat_waits_expired: got %0d want 0", expired); end
        n_compared++;
        if (relock_count !== 8'd255) begin n_mismatched++; $display("[TB] FAIL sat_256: got %0d want 255", relock_count); end
    endtask

    task automatic test_async_reset();
        int n;
        pll_locked = 1'b0;
        n = 0;
        while (n < 50 && state !== 3'd1) begin
            tick();
            n++;
        end
        repeat (3) tick();
        n_compared++;
        if (state !== 3'd1 || relock_count !== 8'd255) begin
            n_mismatched++;
            $display("[TB] FAIL arst_pre: got state=%0d relock=%0d want 1/255", state, relock_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_compared++;
        if (pll_rst !== 1'b1 || ready !== 1'b0 || fault !== 1'b0 || relock_count !== 8'd0 || state !== 3'd0) begin
            n_mismatched++;
            $display("[TB] FAIL arst_values: got pll_rst=%0b ready=%0b fault=%0b relock=%0d state=%0d want 1/0/0/0/0",
                     pll_rst, ready, fault, relock_count, state);
        end
        tick();
        rst_n = 1'b1;
    endtask

`ifdef PLL_SEQ_RESTART_EN
    task automatic test_restart();
        int n;
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        tick();
        rst_n = 1'b1;
        n = 0;
        while (n < 100 && ready !== 1'b1) begin
            tick();
            n++;
        end
        pll_locked = 1'b0;
        n = 0;
        while (n < 300 && fault !== 1'b1) begin
            tick();
            n++;
        end
        n_compared++;
        if (fault !== 1'b1 || relock_count !== 8'd1) begin
            n_mismatched++;
            $display("[TB] FAIL restart_pre_fault: got fault=%0b relock=%0d want 1/1", fault, relock_count);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_compared++;
        if (fault !== 1'b0 || state !== 3'd0 || pll_rst !== 1'b1 || relock_count !== 8'd1) begin
            n_mismatched++;
            $display("[TB] FAIL restart_from_fault: got fault=%0b state=%0d pll_rst=%0b relock=%0d want 0/0/1/1",
                     fault, state, pll_rst, relock_count);
        end
        pll_locked = 1'b1;
        n = 0;
        while (n < 100 && ready !== 1'b1) begin
            tick();
            n++;
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_compared++;
        if (ready !== 1'b0 || state !== 3'd0) begin
            n_mismatched++;
            $display("[TB] FAIL restart_from_run: got ready=%0b state=%0d want 0/0", ready, state);
        end
    endtask
`endif

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b0;
        pll_locked   = 1'b0;
`ifdef PLL_SEQ_RESTART_EN
        restart      = 1'b0;
`endif
        test_reset();
        test_lock_sequence();
        test_loss_filter();
        test_stabilize_glitch();
        test_timeout_fault();
        test_saturation();
        test_async_reset();
`ifdef PLL_SEQ_RESTART_EN
        test_restart();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
